mem_bus_arbiter: RTL and testbench
==================================

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, byte-address width of both masters and the slave.
REQ-002 SHALL have parameter MAX_WAIT, default 4, the number of consecutive lost arbitration cycles after which M1 wins; legal range 1..15.
REQ-003 SHALL have ports `clk` (input, 1) and `rst` (input, 1); there is one clock, and `rst` is synchronous and active-high.
REQ-004 SHALL have M0 (instruction fetch) ports:
  - m0_req (in, 1)
  - m0_addr (in, ADDR_W)
  - m0_gnt (out, 1): request accepted this cycle
  - m0_rvalid (out, 1)
  - m0_rdata (out, 32)
REQ-005 SHALL have M1 (load/store) ports:
  - m1_req (in, 1), m1_we (in, 1)
  - m1_addr (in, ADDR_W), m1_wdata (in, 32), m1_wmask (in, 4)
  - m1_gnt (out, 1), m1_rvalid (out, 1), m1_rdata (out, 32)
REQ-006 SHALL have slave ports:
  - s_en (out, 1), s_we (out, 1)
  - s_addr (out, ADDR_W), s_wdata (out, 32), s_wmask (out, 4)
  - s_rdata (in, 32): valid exactly one cycle after s_en with s_we=0

Function
REQ-007 SHALL grant at most one master per cycle; the granted master's command is driven onto s_* combinationally in the same cycle, and s_en=gnt.
REQ-008 SHALL give M0 priority when both request, except as REQ-010 overrides.
REQ-009 SHALL hold wait_cnt (4 bits): it increments when m1_req=1 and m1_gnt=0, saturates at MAX_WAIT, and clears when m1 is granted or m1_req=0.
REQ-010 SHALL grant M1 over M0 when wait_cnt==MAX_WAIT and both request; M0 then loses that cycle.
REQ-011 SHALL implement response FSM states IDLE, RESP0 and RESP1; it registers the next state at each clk edge.
REQ-012 SHALL transition to RESP0 after an M0 grant, to RESP1 after an M1 read grant, and to IDLE otherwise, including after an M1 write.
REQ-013 SHALL assert m0_rvalid in RESP0 and m1_rvalid in RESP1, each for exactly one cycle; mX_rdata=s_rdata in that cycle and 0 otherwise.
REQ-014 SHALL allow back-to-back grants: a new grant in a RESP state cycle is legal, and the response and the new command overlap.
REQ-015 SHALL keep the M1 write latency at zero: there is no rvalid for writes, and the write is complete at the grant edge.
REQ-016 SHALL drive s_we=0 and s_wdata=0, and ignore s_wmask semantics, for M0 grants, since M0 is read-only.
REQ-017 SHALL drive s_en=0, all s_* outputs to 0, and both gnt to 0 when neither master requests.
REQ-018 SHALL not depend on a requester holding req after gnt; req held high after gnt is a new request.
REQ-019 SHALL give, for a request arriving in the same cycle as a pending response to the same master, the new grant per REQ-008/010; ordering of responses is preserved because latency is fixed at 1.

Reset
REQ-020 SHALL, while rst=1 at a clk edge, set the FSM to IDLE and wait_cnt to 0.
REQ-021 SHALL force m0_gnt, m1_gnt and s_en to 0 while rst=1, regardless of req.
REQ-022 SHALL, on reset mid-transaction, suppress the pending rvalid; no response is delivered for a grant issued in the cycle rst asserts.
REQ-023 SHALL keep all outputs 0 in the first cycle after rst deasserts unless a req is present.

Structure
REQ-024 SHALL place the FSM state encoding (IDLE=0, RESP0=1, RESP1=2) and the MAX_WAIT default in the shared SoC defines package.
REQ-025 SHALL be a single module with no sub-modules; it is instantiated in open_risc_v_soc between the core fetch/LSU ports and the unified memory.

Verification
REQ-026 SHALL be checked for M0 alone: m0_req=1, addr=0x10, memory[0x10]=0xDEADBEEF -> m0_gnt the same cycle, and m0_rvalid=1 with m0_rdata=0xDEADBEEF the next cycle.
REQ-027 SHALL be checked for contention: both req held 6 cycles, MAX_WAIT=4 -> M0 granted cycles 0-3, M1 granted cycle 4, M0 granted cycle 5, and wait_cnt=0 after cycle 4.
REQ-028 SHALL be checked for an M1 write then read: write 0x12345678 with mask 0xF to 0x20, then read 0x20 -> no rvalid after the write, and m1_rvalid with 0x12345678 one cycle after the read grant.
REQ-029 SHALL be checked for a byte write: mask 0x2 with wdata 0x0000AB00 on a word 0 -> subsequent read returns 0x0000AB00.
REQ-030 SHALL be checked for reset mid-access: rst asserted in the M0 grant cycle -> no m0_rvalid, and all outputs are 0 the next cycle.
REQ-031 SHALL be checked for back-to-back M0 reads at 0x0, 0x4, 0x8 -> rvalid on 3 consecutive cycles with matching data.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Shared definitions for the two-master memory bus arbiter: response FSM encoding,
// starvation-limit default and a small saturating-counter helper.
package mem_bus_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StResp0 = 2'd1,
    StResp1 = 2'd2
  } resp_state_e;

  localparam int unsigned MaxWaitDefault = 4;

  function automatic logic [3:0] sat_inc(input logic [3:0] val, input logic [3:0] lim);
    return (val >= lim) ? lim : val + 4'd1;
  endfunction

endpackage

// File: rtl/mem_bus_arbiter.sv
// Fixed-priority arbiter (M0 fetch over M1 load/store) with a starvation escape for M1,
// driving a single-cycle-latency memory and routing read data back to the owner.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned MAX_WAIT = MaxWaitDefault
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [31:0]       m0_rdata,

  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [31:0]       m1_rdata,

  output logic              s_en,
  output logic              s_we,
  output logic [ADDR_W-1:0] s_addr,
  output logic [31:0]       s_wdata,
  output logic [3:0]        s_wmask,
  input  logic [31:0]       s_rdata
);

  localparam logic [3:0] MaxWait = 4'(MAX_WAIT);

  resp_state_e state_q, state_d;
  logic [3:0]  wait_cnt_q, wait_cnt_d;
  logic        m1_win;

  // Grant and command mux
  always_comb begin
    // M1 wins when alone or once it has been starved for MAX_WAIT cycles
    m1_win  = m1_req & (~m0_req | (wait_cnt_q == MaxWait));
    m1_gnt  = ~rst & m1_win;
    m0_gnt  = ~rst & m0_req & ~m1_win;
    s_en    = m0_gnt | m1_gnt;
    s_we    = 1'b0;
    s_addr  = '0;
    s_wdata = '0;
    s_wmask = '0;
    if (m0_gnt) begin
      s_addr = m0_addr;
    end else if (m1_gnt) begin
      s_we    = m1_we;
      s_addr  = m1_addr;
      s_wdata = m1_wdata;
      s_wmask = m1_wmask;
    end
  end

  // Next state for the starvation counter and response FSM
  always_comb begin
    wait_cnt_d = '0;
    if (m1_req && !m1_gnt) begin
      wait_cnt_d = sat_inc(wait_cnt_q, MaxWait);
    end

    state_d = StIdle;
    if (m0_gnt) begin
      state_d = StResp0;
    end else if (m1_gnt && !m1_we) begin
      state_d = StResp1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Responses are exactly one cycle after the read grant; reset drops any in flight
  always_comb begin
    m0_rvalid = ~rst & (state_q == StResp0);
    m1_rvalid = ~rst & (state_q == StResp1);
    m0_rdata  = m0_rvalid ? s_rdata : 32'h0;
    m1_rdata  = m1_rvalid ? s_rdata : 32'h0;
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Randomised and directed bench for mem_bus_arbiter with a behavioural memory and reference model.
module tb_mem_bus_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned MW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req;
  logic [AW-1:0] m0_addr;
  logic          m0_gnt, m0_rvalid;
  logic [31:0]   m0_rdata;
  logic          m1_req, m1_we;
  logic [AW-1:0] m1_addr;
  logic [31:0]   m1_wdata;
  logic [3:0]    m1_wmask;
  logic          m1_gnt, m1_rvalid;
  logic [31:0]   m1_rdata;
  logic          s_en, s_we;
  logic [AW-1:0] s_addr;
  logic [31:0]   s_wdata;
  logic [3:0]    s_wmask;
  logic [31:0]   s_rdata = 32'h0;

  int n_vec = 0;
  int n_err = 0;

  mem_bus_arbiter #(
    .ADDR_W  (AW),
    .MAX_WAIT(MW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .m0_req   (m0_req),
    .m0_addr  (m0_addr),
    .m0_gnt   (m0_gnt),
    .m0_rvalid(m0_rvalid),
    .m0_rdata (m0_rdata),
    .m1_req   (m1_req),
    .m1_we    (m1_we),
    .m1_addr  (m1_addr),
    .m1_wdata (m1_wdata),
    .m1_wmask (m1_wmask),
    .m1_gnt   (m1_gnt),
    .m1_rvalid(m1_rvalid),
    .m1_rdata (m1_rdata),
    .s_en     (s_en),
    .s_we     (s_we),
    .s_addr   (s_addr),
    .s_wdata  (s_wdata),
    .s_wmask  (s_wmask),
    .s_rdata  (s_rdata)
  );

  always #5 clk = ~clk;

  // Slave memory: acts only on what the DUT drives on s_*
  logic [31:0] slv_mem [256];
  always @(posedge clk) begin
    if (s_en) begin
      if (s_we) begin
        for (int b = 0; b < 4; b++)
          if (s_wmask[b]) slv_mem[s_addr[9:2]][8*b +: 8] <= s_wdata[8*b +: 8];
      end else begin
        s_rdata <= slv_mem[s_addr[9:2]];
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expected view of the bus from the arbitration rules
  logic [31:0] ref_mem [256];
  int          wait_m = 0;
  int          pend_m = 0;       // 0 none, 1 M0 read, 2 M1 read
  logic [31:0] pend_data = 32'h0;
  bit          run = 1'b0;

  always @(negedge clk) begin
    if (run) begin
      logic        e_g0, e_g1, e_we;
      logic [31:0] e_addr, e_wd, e_rd0, e_rd1;
      logic [3:0]  e_wm;
      logic        e_rv0, e_rv1;
      int          idx;
      e_g0 = 0; e_g1 = 0; e_we = 0; e_addr = 0; e_wd = 0; e_wm = 0;
      e_rv0 = 0; e_rv1 = 0; e_rd0 = 0; e_rd1 = 0;
      if (!rst) begin
        if (m0_req && m1_req) begin
          if (wait_m == MW) e_g1 = 1; else e_g0 = 1;
        end else begin
          e_g0 = m0_req;
          e_g1 = m1_req;
        end
        if (e_g0) e_addr = m0_addr;
        if (e_g1) begin
          e_addr = m1_addr; e_we = m1_we; e_wd = m1_wdata; e_wm = m1_wmask;
        end
        e_rv0 = (pend_m == 1);
        e_rv1 = (pend_m == 2);
        if (e_rv0) e_rd0 = pend_data;
        if (e_rv1) e_rd1 = pend_data;
      end
      chk("gnt", {62'b0, m0_gnt, m1_gnt}, {62'b0, e_g0, e_g1});
      chk("s_en_we", {62'b0, s_en, s_we}, {62'b0, e_g0 | e_g1, e_we});
      chk("s_addr", 64'(s_addr), 64'(e_addr));
      chk("s_wdata_wmask", {28'b0, s_wdata, s_wmask}, {28'b0, e_wd, e_wm});
      chk("rvalid", {62'b0, m0_rvalid, m1_rvalid}, {62'b0, e_rv0, e_rv1});
      chk("rdata", {m0_rdata, m1_rdata}, {e_rd0, e_rd1});
      // advance to the next edge
      if (rst) begin
        wait_m = 0;
        pend_m = 0;
      end else begin
        idx    = int'(e_addr[9:2]);
        pend_m = 0;
        if (e_g0 || (e_g1 && !e_we)) begin
          pend_m    = e_g0 ? 1 : 2;
          pend_data = ref_mem[idx];
        end
        if (e_g1 && e_we)
          for (int b = 0; b < 4; b++)
            if (e_wm[b]) ref_mem[idx][8*b +: 8] = e_wd[8*b +: 8];
        if (m1_req && !e_g1) wait_m = (wait_m >= MW) ? MW : wait_m + 1;
        else wait_m = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r0, input logic [31:0] a0, input logic r1, input logic we,
                       input logic [31:0] a1, input logic [31:0] wd, input logic [3:0] wm);
    m0_req = r0; m0_addr = a0;
    m1_req = r1; m1_we = we; m1_addr = a1; m1_wdata = wd; m1_wmask = wm;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0);
  endtask

  logic [31:0] init_word;

  initial begin
    for (int i = 0; i < 256; i++) begin
      init_word  = 32'(i) * 32'h0101_0101 ^ 32'h5A00_0000;
      slv_mem[i] = init_word;
      ref_mem[i] = init_word;
    end
    slv_mem[4] = 32'hDEAD_BEEF;   ref_mem[4] = 32'hDEAD_BEEF;
    slv_mem[0] = 32'h1111_0000;   ref_mem[0] = 32'h1111_0000;
    slv_mem[1] = 32'h2222_0004;   ref_mem[1] = 32'h2222_0004;
    slv_mem[2] = 32'h3333_0008;   ref_mem[2] = 32'h3333_0008;

    rst = 1'b1;
    drive(1, 32'h10, 1, 0, 32'h40, 0, 0);   // requests under reset must not be granted
    run = 1'b1;
    step(); step();
    @(negedge clk);
    chk("reset_gnt", {62'b0, m0_gnt, m1_gnt}, 64'd0);
    chk("reset_s_en", {63'b0, s_en}, 64'd0);

    // M0 alone
    step(); rst = 1'b0; drive(1, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("m0_alone_gnt", {63'b0, m0_gnt}, 64'd1);
    step(); idle();
    @(negedge clk);
    chk("m0_alone_rvalid", {63'b0, m0_rvalid}, 64'd1);
    chk("m0_alone_rdata", 64'(m0_rdata), 64'hDEAD_BEEF);

    // Contention, both held six cycles
    for (int k = 0; k < 6; k++) begin
      step(); drive(1, 32'h80, 1, 0, 32'h40, 0, 0);
      @(negedge clk);
      chk("contend_m0_gnt", {63'b0, m0_gnt}, {63'b0, k != 4});
      chk("contend_m1_gnt", {63'b0, m1_gnt}, {63'b0, k == 4});
      if (k == 5) chk("contend_wait_clr", 64'(dut.wait_cnt_q), 64'd0);
    end
    step(); idle();

    // M1 write then read
    step(); drive(0, 0, 1, 1, 32'h20, 32'h1234_5678, 4'hF);
    step(); drive(0, 0, 1, 0, 32'h20, 0, 0);
    @(negedge clk);
    chk("wr_no_rvalid", {63'b0, m1_rvalid}, 64'd0);
    step(); idle();
    @(negedge clk);
    chk("rd_rvalid", {63'b0, m1_rvalid}, 64'd1);
    chk("rd_rdata", 64'(m1_rdata), 64'h1234_5678);

    // Byte write into a zeroed word
    step(); drive(0, 0, 1, 1, 32'h24, 32'h0, 4'hF);
    step(); drive(0, 0, 1, 1, 32'h24, 32'hFFFF_AB77, 4'h2);
    step(); drive(0, 0, 1, 0, 32'h24, 0, 0);
    step(); idle();
    @(negedge clk);
    chk("byte_wr_rdata", 64'(m1_rdata), 64'h0000_AB00);

    // Reset in the M0 grant cycle
    step(); rst = 1'b1; drive(1, 32'h10, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rst_mid_gnt", {62'b0, m0_gnt, s_en}, 64'd0);
    step(); rst = 1'b0; idle();
    @(negedge clk);
    chk("rst_mid_outs", {59'b0, m0_rvalid, m1_rvalid, m0_gnt, m1_gnt, s_en}, 64'd0);
    chk("rst_mid_data", {m0_rdata, m1_rdata}, 64'd0);

    // Back-to-back M0 reads
    step(); drive(1, 32'h0, 0, 0, 0, 0, 0);
    step(); drive(1, 32'h4, 0, 0, 0, 0, 0);
    @(negedge clk); chk("b2b_0", {31'b0, m0_rvalid, m0_rdata}, {31'b0, 1'b1, 32'h1111_0000});
    step(); drive(1, 32'h8, 0, 0, 0, 0, 0);
    @(negedge clk); chk("b2b_1", {31'b0, m0_rvalid, m0_rdata}, {31'b0, 1'b1, 32'h2222_0004});
    step(); idle();
    @(negedge clk); chk("b2b_2", {31'b0, m0_rvalid, m0_rdata}, {31'b0, 1'b1, 32'h3333_0008});

    // Random traffic, model checks every cycle
    for (int n = 0; n < 3000; n++) begin
      step();
      rst = ($urandom % 64) == 0;
      drive(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0, $urandom % 2,
            $urandom, $urandom, 4'($urandom));
    end
    step(); rst = 1'b0; idle();
    step(); step();
    run = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
